fpc_issue_queue: RTL
====================

// Module: fpc_issue_queue
// PURPOSE
//  Operand front-end for the bf16 FP add/mul core (Fpc). Buffers {a,b,mode} requests in a FIFO.
//  Issues one request at a time to the core as a single-cycle in_valid pulse.
//  Captures the core's one-cycle out_valid/out result and holds it on a valid/ready result port.
//  Keeps at most one operation outstanding, because the core ignores in_valid while it is busy.
// PARAMETERS
//  DEPTH    4  operand FIFO entries (power of 2, >=2)
//  TIMEOUT  8  max cycles in WAIT before the watchdog fires (only with FPC_ISSUE_TIMEOUT_EN)
// PORTS
//  clk            in   1   single clock, all flops posedge
//  rst            in   1   asynchronous, active-high reset
//  op_valid       in   1   request valid
//  op_ready       out  1   request accepted when op_valid&op_ready; equals !full
//  op_a           in   16  bf16 operand A
//  op_b           in   16  bf16 operand B
//  op_mode        in   1   0=add, 1=mul
//  fpc_in_valid   out  1   one-cycle issue pulse to the core
//  fpc_in_a       out  16  operand A to the core
//  fpc_in_b       out  16  operand B to the core
//  fpc_mode       out  1   mode to the core
//  fpc_out_valid  in   1   core result strobe (one cycle)
//  fpc_out        in   16  core result
//  res_valid      out  1   result held until res_ready
//  res_ready      in   1   result consumer ready
//  res_data       out  16  bf16 result
//  res_err        out  1   watchdog result flag (tied 0 when the macro is undefined)
//  count          out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  Reset values: every output is 0, except op_ready=1. FIFO pointers=0, state=IDLE.
//  Interface: fpc_in_a, fpc_in_b and fpc_mode are registered. They stay stable from the issue cycle until the next issue.
//  FIFO:
//   - Push on op_valid&op_ready.
//   - Pop on the IDLE->ISSUE transition.
//   - Push and pop in the same cycle leave count unchanged.
//   - When full, op_ready=0 even if a pop occurs that cycle (no pass-through).
//   - Pointers wrap modulo DEPTH.
//  FSM:
//   - IDLE:
//     - If count!=0, pop the head.
//     - Register the head's fields onto fpc_in_*.
//     - Go to ISSUE.
//   - ISSUE:
//     - fpc_in_valid=1 for exactly this cycle.
//     - Go to WAIT.
//   - WAIT:
//     - On fpc_out_valid, capture fpc_out into res_data, set res_valid=1, go to HOLD.
//     - fpc_out_valid in any other state is ignored.
//   - HOLD:
//     - res_valid=1; res_data is stable.
//     - On res_ready, clear res_valid and go to IDLE.
//     - No new issue occurs while in HOLD.
//  Latency: the op handshake at edge E0 into an empty FIFO in IDLE gives the following timeline.
//   - fpc_in_valid is high in the cycle after E1.
//   - The core's out_valid arrives after E3.
//   - res_valid is high after E4.
//   - Minimum total: 4 cycles. Back-to-back throughput is 1 op per 5 cycles with res_ready=1.
//  Simultaneous events:
//   - A push into an empty FIFO is not visible to IDLE until the following cycle.
//   - res_ready with res_valid=0 is ignored.
//  Reset mid-operation:
//   - Flushes the FIFO and drops any in-flight result.
//   - The core must be reset in the same cycle; the integrator inverts rst for the core's rst_n.
// CONFIGURATION
//  FPC_ISSUE_TIMEOUT_EN defined:
//   - A counter runs in WAIT.
//   - If TIMEOUT cycles pass without fpc_out_valid: res_data=16'h7FC0 (bf16 qNaN), res_err=1, go to HOLD.
//   - res_err clears when the result handshake completes.
//  FPC_ISSUE_TIMEOUT_EN undefined:
//   - WAIT blocks indefinitely.
//   - res_err is constant 0 and no counter is built.
// TESTING
//  Add: a=16'h3F80, b=16'h4000, mode=0, real Fpc attached -> res_data=16'h4040, res_valid 4 cycles after accept.
//  Mul: a=16'h4000, b=16'h4040, mode=1 -> res_data=16'h40C0, res_err=0.
//  Backpressure: res_ready=0, push 6 ops at DEPTH=4.
//   -> 5 accepted, then op_ready=0 and count=4.
//   -> Results drain in order once res_ready=1.
//  Ordering: 3 ops (add, mul, add), res_ready randomly toggled -> 3 results in FIFO order.
//   -> fpc_in_valid is never asserted outside ISSUE.
//  Watchdog (macro on): core stub never strobes.
//   -> res_data=16'h7FC0, res_err=1 after TIMEOUT=8 WAIT cycles.
//   -> With the macro off, the block stays in WAIT.
//  Reset: assert rst during WAIT with 2 ops queued.
//   -> count=0, res_valid=0, op_ready=1 immediately.
//   -> After release, no issue occurs until a new push.

Source files
------------

// File: rtl/fpc_issue_queue.sv
// Operand FIFO and single-outstanding issue sequencer in front of the bf16 Fpc add/mul core.
// Optional WAIT watchdog enabled by defining FPC_ISSUE_TIMEOUT_EN.
module fpc_issue_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [15:0]                  op_a,
  input  logic [15:0]                  op_b,
  input  logic                         op_mode,
  output logic                         fpc_in_valid,
  output logic [15:0]                  fpc_in_a,
  output logic [15:0]                  fpc_in_b,
  output logic                         fpc_mode,
  input  logic                         fpc_out_valid,
  input  logic [15:0]                  fpc_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [15:0]                  res_data,
  output logic                         res_err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = 33;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_bad_cfg
    $error("fpc_issue_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   mem [DEPTH];
  logic [OW-1:0]   head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  logic [CW-1:0]   count_nxt;
  logic            in_valid_d, mode_d, res_valid_d;
  logic [15:0]     a_d, b_d, res_data_d;

  assign push      = op_valid & op_ready;
  assign head      = mem[rd_ptr];
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Operand storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {op_mode, op_a, op_b};
  end

  // FIFO pointers and occupancy; ready is registered from next occupancy so full blocks pushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      op_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      op_ready <= (count_nxt != CW'(DEPTH));
    end
  end

`ifdef FPC_ISSUE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q, wd_d;
  logic          res_err_d;
`endif

  // Next-state and registered-output values
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    in_valid_d  = 1'b0;
    a_d         = fpc_in_a;
    b_d         = fpc_in_b;
    mode_d      = fpc_mode;
    res_valid_d = res_valid;
    res_data_d  = res_data;
`ifdef FPC_ISSUE_TIMEOUT_EN
    wd_d        = wd_q;
    res_err_d   = res_err;
`endif
    case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          pop                = 1'b1;
          {mode_d, a_d, b_d} = head;
          in_valid_d         = 1'b1;
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FPC_ISSUE_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        if (fpc_out_valid) begin
          res_data_d  = fpc_out;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
`ifdef FPC_ISSUE_TIMEOUT_EN
        else if (wd_q == TW'(TIMEOUT - 1)) begin
          res_data_d  = 16'h7FC0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          wd_d = wd_q + TW'(1);
        end
`endif
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
`ifdef FPC_ISSUE_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fpc_in_valid <= 1'b0;
      fpc_in_a     <= '0;
      fpc_in_b     <= '0;
      fpc_mode     <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
    end else begin
      state_q      <= state_d;
      fpc_in_valid <= in_valid_d;
      fpc_in_a     <= a_d;
      fpc_in_b     <= b_d;
      fpc_mode     <= mode_d;
      res_valid    <= res_valid_d;
      res_data     <= res_data_d;
    end
  end

`ifdef FPC_ISSUE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q    <= '0;
      res_err <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      res_err <= res_err_d;
    end
  end
`else
  assign res_err = 1'b0;
`endif

endmodule
